datapath_pipelined: RTL and testbench

Parametrised two-stage successor to the single-cycle CR16 datapath.
- Stage EX: register-file read, immediate mux, ALU, external-data mux. Results are captured into a writeback (WB) pipeline register.
- Stage WB: writes the captured result into the register file one cycle later.
- Adds a valid/ready issue handshake, read-after-write hazard handling (forwarding or stall), and registered status flags. Sits between the controller/decoder and the memory interface.

---
 rtl/cr16_pkg.sv | 25 ++
 rtl/datapath_pipelined_hazard.sv | 28 ++
 rtl/datapath_pipelined.sv | 161 ++++++++++++++++
 tb/tb_datapath_pipelined.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/cr16_pkg.sv
// Shared CR16 datapath definitions: ALU opcodes and status flag layout.
//   OP_*        : 4-bit ALU opcodes (opcode_t)
//   FLAG_WIDTH  : width of the status flag vector
//   FLAG_C/L/F/Z/N : bit positions of carry, low, flag(overflow), zero, negative
package cr16_pkg;
   localparam int FLAG_WIDTH = 5;
   localparam int FLAG_C = 0;   // carry / borrow out of bit P_WIDTH-1
   localparam int FLAG_L = 1;   // unsigned A < B (SUB/CMP)
   localparam int FLAG_F = 2;   // signed overflow out of bit P_WIDTH-1
   localparam int FLAG_Z = 3;   // zero
   localparam int FLAG_N = 4;   // negative

   typedef enum logic [3:0] {
      OP_ADD = 4'd0,   // A + B
      OP_SUB = 4'd1,   // A - B
      OP_AND = 4'd2,
      OP_OR  = 4'd3,
      OP_XOR = 4'd4,
      OP_MOV = 4'd5,   // result = A
      OP_CMP = 4'd6,   // result = B, flags from A vs B
      OP_SHL = 4'd7,   // A << 1, carry = A msb
      OP_SHR = 4'd8,   // A >> 1 logical, carry = A lsb
      OP_NOT = 4'd9    // ~A
   } opcode_t;
endpackage

// File: rtl/datapath_pipelined_hazard.sv
// datapath_hazard_unit: combinational read-after-write detection against the
// op held in the WB register.
//   i_a_sel, i_b_sel : source selects of the op being issued
//   i_imm_sel        : A operand comes from the immediate (A cannot hazard)
//   i_wb_dest/valid/write : state of the WB register
//   o_fwd_a, o_fwd_b : operand needs the WB result
//   o_stall          : any operand hazard this cycle
module datapath_hazard_unit #(
   parameter int P_SEL_W = 4
) (
   input  logic [P_SEL_W-1:0] i_a_sel,
   input  logic [P_SEL_W-1:0] i_b_sel,
   input  logic               i_imm_sel,
   input  logic [P_SEL_W-1:0] i_wb_dest,
   input  logic               i_wb_valid,
   input  logic               i_wb_write,
   output logic               o_fwd_a,
   output logic               o_fwd_b,
   output logic               o_stall
);
   logic w_wb_live;

   // A WB op that does not write can never create a dependency.
   assign w_wb_live = i_wb_valid & i_wb_write;
   assign o_fwd_a   = w_wb_live & ~i_imm_sel & (i_wb_dest == i_a_sel);
   assign o_fwd_b   = w_wb_live & (i_wb_dest == i_b_sel);
   assign o_stall   = o_fwd_a | o_fwd_b;
endmodule

// File: rtl/datapath_pipelined.sv
// datapath_pipelined: two-stage (EX / WB) CR16 datapath.
//   EX: register read (+forward), immediate mux, ALU, external data mux,
//       capture into the WB register on an accepted issue.
//   WB: writes the captured result into the register file on the next
//       enabled edge.
// Build option: DATAPATH_PIPELINED_FORWARD_EN -- when defined, RAW hazards are
// resolved by forwarding O_RESULT_BUS; otherwise O_READY drops for one cycle.
// Ports:
//   I_CLK, I_NRESET (sync, active low), I_ENABLE (global advance)
//   I_VALID / O_READY issue handshake
//   I_REG_A_SELECT, I_REG_B_SELECT, I_DEST_SELECT, I_DEST_WRITE
//   I_IMMEDIATE, I_IMMEDIATE_SELECT, I_OPCODE
//   I_REGFILE_DATA, I_REGFILE_DATA_SELECT (external data into WB)
//   O_A, O_B (forwarded operands), O_RESULT_BUS, O_RESULT_VALID, O_STATUS_FLAGS
module datapath_pipelined
   import cr16_pkg::*;
#(
   parameter int P_WIDTH    = 16,
   parameter int P_NUM_REGS = 16,
   parameter int P_SEL_W    = $clog2(P_NUM_REGS)
) (
   input  logic                  I_CLK,
   input  logic                  I_NRESET,
   input  logic                  I_ENABLE,
   input  logic                  I_VALID,
   output logic                  O_READY,
   input  logic [P_SEL_W-1:0]    I_REG_A_SELECT,
   input  logic [P_SEL_W-1:0]    I_REG_B_SELECT,
   input  logic [P_SEL_W-1:0]    I_DEST_SELECT,
   input  logic                  I_DEST_WRITE,
   input  logic [P_WIDTH-1:0]    I_IMMEDIATE,
   input  logic                  I_IMMEDIATE_SELECT,
   input  opcode_t               I_OPCODE,
   input  logic [P_WIDTH-1:0]    I_REGFILE_DATA,
   input  logic                  I_REGFILE_DATA_SELECT,
   output logic [P_WIDTH-1:0]    O_A,
   output logic [P_WIDTH-1:0]    O_B,
   output logic [P_WIDTH-1:0]    O_RESULT_BUS,
   output logic                  O_RESULT_VALID,
   output logic [FLAG_WIDTH-1:0] O_STATUS_FLAGS
);
   localparam int MSB = P_WIDTH - 1;

   logic [P_WIDTH-1:0]    r_regs [P_NUM_REGS];
   logic [P_WIDTH-1:0]    r_wb_data;
   logic [P_SEL_W-1:0]    r_wb_dest;
   logic                  r_wb_write;
   logic                  r_wb_valid;
   logic [FLAG_WIDTH-1:0] r_flags;

   logic                  w_fwd_a, w_fwd_b, w_stall, w_accept;
   logic [P_WIDTH-1:0]    w_a_raw, w_b_raw, w_a_op, w_res;
   logic                  w_c, w_l, w_f, w_z, w_n;
   logic [FLAG_WIDTH-1:0] w_flags;

   datapath_hazard_unit #(.P_SEL_W(P_SEL_W)) u_hazard (
      .i_a_sel    (I_REG_A_SELECT),
      .i_b_sel    (I_REG_B_SELECT),
      .i_imm_sel  (I_IMMEDIATE_SELECT),
      .i_wb_dest  (r_wb_dest),
      .i_wb_valid (r_wb_valid),
      .i_wb_write (r_wb_write),
      .o_fwd_a    (w_fwd_a),
      .o_fwd_b    (w_fwd_b),
      .o_stall    (w_stall)
   );

   assign w_a_raw = r_regs[I_REG_A_SELECT];
   assign w_b_raw = r_regs[I_REG_B_SELECT];

`ifdef DATAPATH_PIPELINED_FORWARD_EN
   assign O_A     = w_fwd_a ? r_wb_data : w_a_raw;
   assign O_B     = w_fwd_b ? r_wb_data : w_b_raw;
   assign O_READY = I_ENABLE;
`else
   // Without forwarding the stall guarantees the raw values are current
   // whenever an op is actually accepted.
   assign O_A     = w_a_raw;
   assign O_B     = w_b_raw;
   assign O_READY = I_ENABLE & ~w_stall;
`endif

   assign w_accept = I_VALID & O_READY;   // O_READY already includes I_ENABLE
   assign w_a_op   = I_IMMEDIATE_SELECT ? I_IMMEDIATE : O_A;

   // ALU
   always_comb begin
      w_res = '0;
      w_c   = 1'b0;
      w_l   = 1'b0;
      w_f   = 1'b0;
      case (I_OPCODE)
         OP_ADD: begin
            {w_c, w_res} = {1'b0, w_a_op} + {1'b0, O_B};
            w_f = (w_a_op[MSB] == O_B[MSB]) && (w_res[MSB] != w_a_op[MSB]);
         end
         OP_SUB: begin
            {w_c, w_res} = {1'b0, w_a_op} - {1'b0, O_B};   // carry = borrow
            w_f = (w_a_op[MSB] != O_B[MSB]) && (w_res[MSB] != w_a_op[MSB]);
            w_l = (w_a_op < O_B);
         end
         OP_AND: w_res = w_a_op & O_B;
         OP_OR:  w_res = w_a_op | O_B;
         OP_XOR: w_res = w_a_op ^ O_B;
         OP_MOV: w_res = w_a_op;
         OP_CMP: begin
            w_res = O_B;
            w_l   = (w_a_op < O_B);
         end
         OP_SHL: {w_c, w_res} = {w_a_op, 1'b0};
         OP_SHR: begin
            w_res = w_a_op >> 1;
            w_c   = w_a_op[0];
         end
         OP_NOT: w_res = ~w_a_op;
         default: w_res = '0;
      endcase
      // CMP reports the comparison, not its pass-through result.
      if (I_OPCODE == OP_CMP) begin
         w_z = (w_a_op == O_B);
         w_n = ($signed(w_a_op) < $signed(O_B));
      end else begin
         w_z = (w_res == '0);
         w_n = w_res[MSB];
      end
   end

   always_comb begin
      w_flags         = '0;
      w_flags[FLAG_C] = w_c;
      w_flags[FLAG_L] = w_l;
      w_flags[FLAG_F] = w_f;
      w_flags[FLAG_Z] = w_z;
      w_flags[FLAG_N] = w_n;
   end

   always_ff @(posedge I_CLK) begin
      if (!I_NRESET) begin
         for (int i = 0; i < P_NUM_REGS; i++) r_regs[i] <= '0;
         r_wb_data  <= '0;
         r_wb_dest  <= '0;
         r_wb_write <= 1'b0;
         r_wb_valid <= 1'b0;
         r_flags    <= '0;
      end else if (I_ENABLE) begin
         if (r_wb_valid && r_wb_write) r_regs[r_wb_dest] <= r_wb_data;
         r_wb_valid <= w_accept;
         if (w_accept) begin
            r_wb_data  <= I_REGFILE_DATA_SELECT ? I_REGFILE_DATA : w_res;
            r_wb_dest  <= I_DEST_SELECT;
            r_wb_write <= I_DEST_WRITE;
            // Loads bypass the ALU and leave the flags of the last ALU op.
            if (!I_REGFILE_DATA_SELECT) r_flags <= w_flags;
         end
      end
   end

   assign O_RESULT_BUS   = r_wb_data;
   assign O_RESULT_VALID = r_wb_valid;
   assign O_STATUS_FLAGS = r_flags;
endmodule

// File: tb/tb_datapath_pipelined.sv
module tb_datapath_pipelined;
   import cr16_pkg::*;

   logic        I_CLK = 1'b0;
   logic        I_NRESET, I_ENABLE, I_VALID, O_READY;
   logic [3:0]  I_REG_A_SELECT, I_REG_B_SELECT, I_DEST_SELECT;
   logic        I_DEST_WRITE, I_IMMEDIATE_SELECT, I_REGFILE_DATA_SELECT;
   logic [15:0] I_IMMEDIATE, I_REGFILE_DATA;
   opcode_t     I_OPCODE;
   logic [15:0] O_A, O_B, O_RESULT_BUS;
   logic        O_RESULT_VALID;
   logic [4:0]  O_STATUS_FLAGS;

   int n_vec = 0;
   int n_err = 0;

   datapath_pipelined #(.P_WIDTH(16), .P_NUM_REGS(16)) dut (
      .I_CLK(I_CLK), .I_NRESET(I_NRESET), .I_ENABLE(I_ENABLE),
      .I_VALID(I_VALID), .O_READY(O_READY),
      .I_REG_A_SELECT(I_REG_A_SELECT), .I_REG_B_SELECT(I_REG_B_SELECT),
      .I_DEST_SELECT(I_DEST_SELECT), .I_DEST_WRITE(I_DEST_WRITE),
      .I_IMMEDIATE(I_IMMEDIATE), .I_IMMEDIATE_SELECT(I_IMMEDIATE_SELECT),
      .I_OPCODE(I_OPCODE), .I_REGFILE_DATA(I_REGFILE_DATA),
      .I_REGFILE_DATA_SELECT(I_REGFILE_DATA_SELECT),
      .O_A(O_A), .O_B(O_B), .O_RESULT_BUS(O_RESULT_BUS),
      .O_RESULT_VALID(O_RESULT_VALID), .O_STATUS_FLAGS(O_STATUS_FLAGS)
   );

   always #5 I_CLK = ~I_CLK;

   localparam logic [4:0] F_C = 5'd1 << FLAG_C;
   localparam logic [4:0] F_L = 5'd1 << FLAG_L;
   localparam logic [4:0] F_Z = 5'd1 << FLAG_Z;
   localparam logic [4:0] F_N = 5'd1 << FLAG_N;

`ifdef DATAPATH_PIPELINED_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   task automatic tick();
      @(posedge I_CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one issue request (ALU op or load).
   task automatic drv(input logic v, input opcode_t op, input logic [3:0] a, input logic [3:0] b,
                      input logic isel, input logic [15:0] imm, input logic [3:0] d,
                      input logic dw, input logic dsel, input logic [15:0] data);
      I_VALID = v; I_OPCODE = op; I_REG_A_SELECT = a; I_REG_B_SELECT = b;
      I_IMMEDIATE_SELECT = isel; I_IMMEDIATE = imm; I_DEST_SELECT = d;
      I_DEST_WRITE = dw; I_REGFILE_DATA_SELECT = dsel; I_REGFILE_DATA = data;
   endtask

   initial begin
      I_NRESET = 1'b0; I_ENABLE = 1'b1;
      drv(0, OP_ADD, 0, 0, 0, 16'h0, 0, 0, 0, 16'h0);
      tick(); tick();
      chk("rst_valid", O_RESULT_VALID, 0);
      chk("rst_bus",   O_RESULT_BUS, 0);
      chk("rst_flags", O_STATUS_FLAGS, 0);
      chk("rst_r0",    O_A, 0);
      I_NRESET = 1'b1;

      // 1: r1 = r0 + 5
      drv(1, OP_ADD, 0, 0, 1, 16'd5, 1, 1, 0, 16'h0);
      #1 chk("t1_ready", O_READY, 1);
      tick();
      chk("t1_valid", O_RESULT_VALID, 1);
      chk("t1_bus",   O_RESULT_BUS, 5);
      chk("t1_flags", O_STATUS_FLAGS, 0);
      drv(0, OP_ADD, 1, 0, 0, 16'h0, 0, 0, 0, 16'h0);
      tick();
      chk("t1_wb_idle", O_RESULT_VALID, 0);
      chk("t1_r1",      O_A, 5);

      // 2: r4 = r0 + 5 ; r5 = r4 + r4 (dependent on both operands)
      drv(1, OP_ADD, 0, 0, 1, 16'd5, 4, 1, 0, 16'h0);
      tick();
      drv(1, OP_ADD, 4, 4, 0, 16'h0, 5, 1, 0, 16'h0);
      #1;
      chk("t2_ready_hazard", O_READY, FWD ? 1 : 0);
      chk("t2_a_hazard",     O_A, FWD ? 5 : 0);
      chk("t2_b_hazard",     O_B, FWD ? 5 : 0);
      tick();
      if (!FWD) begin
         chk("t2_stall_wb", O_RESULT_VALID, 0);
         chk("t2_ready_2nd", O_READY, 1);
         chk("t2_a_retired", O_A, 5);
         tick();
      end
      chk("t2_valid", O_RESULT_VALID, 1);
      chk("t2_bus",   O_RESULT_BUS, 10);
      drv(0, OP_ADD, 0, 5, 0, 16'h0, 0, 0, 0, 16'h0);
      tick();
      chk("t2_r5", O_B, 10);

      // 3: WB op does not write -> no hazard, raw register value seen
      drv(1, OP_ADD, 0, 0, 1, 16'd3, 6, 0, 0, 16'h0);
      tick();
      chk("t3_bus_nowrite", O_RESULT_BUS, 3);
      drv(1, OP_ADD, 6, 6, 0, 16'h0, 7, 1, 0, 16'h0);
      #1;
      chk("t3_ready", O_READY, 1);
      chk("t3_a_raw", O_A, 0);
      tick();
      chk("t3_bus",   O_RESULT_BUS, 0);
      chk("t3_flags", O_STATUS_FLAGS, F_Z);

      // 4: r8 = 2 - r4(5) = FFFD, then freeze 3 cycles
      drv(1, OP_SUB, 0, 4, 1, 16'd2, 8, 1, 0, 16'h0);
      tick();
      chk("t4_bus",   O_RESULT_BUS, 16'hFFFD);
      chk("t4_flags", O_STATUS_FLAGS, F_C | F_L | F_N);
      I_ENABLE = 1'b0;
      drv(1, OP_XOR, 0, 8, 1, 16'h00FF, 9, 1, 0, 16'h0);
      for (int i = 0; i < 3; i++) begin
         #1 chk("t4_frz_ready", O_READY, 0);
         tick();
         chk("t4_frz_valid", O_RESULT_VALID, 1);
         chk("t4_frz_bus",   O_RESULT_BUS, 16'hFFFD);
         chk("t4_frz_flags", O_STATUS_FLAGS, F_C | F_L | F_N);
         chk("t4_frz_r8",    O_B, FWD ? 16'hFFFD : 16'h0);
      end
      I_ENABLE = 1'b1;
      drv(0, OP_ADD, 0, 8, 0, 16'h0, 0, 0, 0, 16'h0);
      tick();
      chk("t4_valid_after", O_RESULT_VALID, 0);
      chk("t4_r8",          O_B, 16'hFFFD);

      // 5: load BEEF into r3; flags hold; then SUB r3-r3 sets Z
      drv(1, OP_ADD, 0, 0, 1, 16'h1, 3, 1, 1, 16'hBEEF);
      tick();
      chk("t5_bus",   O_RESULT_BUS, 16'hBEEF);
      chk("t5_flags", O_STATUS_FLAGS, F_C | F_L | F_N);
      drv(0, OP_ADD, 3, 0, 0, 16'h0, 0, 0, 0, 16'h0);
      tick();
      chk("t5_r3", O_A, 16'hBEEF);
      drv(1, OP_SUB, 3, 3, 0, 16'h0, 9, 1, 0, 16'h0);
      tick();
      chk("t5_sub_bus",   O_RESULT_BUS, 0);
      chk("t5_sub_flags", O_STATUS_FLAGS, F_Z);

      // 6: reset while a writing op is in WB
      drv(1, OP_ADD, 0, 0, 1, 16'h1234, 10, 1, 0, 16'h0);
      tick();
      chk("t6_valid", O_RESULT_VALID, 1);
      drv(1, OP_ADD, 10, 0, 1, 16'h7, 11, 1, 0, 16'h0);
      #1 chk("t6_imm_no_hazard", O_READY, 1);
      drv(0, OP_ADD, 10, 3, 0, 16'h0, 0, 0, 0, 16'h0);
      I_NRESET = 1'b0;
      tick();
      I_NRESET = 1'b1;
      #1;
      chk("t6_valid_rst", O_RESULT_VALID, 0);
      chk("t6_flags_rst", O_STATUS_FLAGS, 0);
      chk("t6_bus_rst",   O_RESULT_BUS, 0);
      chk("t6_r10",       O_A, 0);
      chk("t6_r3",        O_B, 0);
      tick();
      chk("t6_r10_later", O_A, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
